// File: rtl/led_pkg.sv
// Shared types and helpers for the 2x4 RYGB LED panel controller.
// LED codes, panel layout, FSM states and panel helper functions.
package led_pkg;

  typedef enum logic [1:0] {
    BLU = 2'd0,
    GRN = 2'd1,
    YEL = 2'd2,
    RED = 2'd3
  } LED_t;

  typedef LED_t [3:0] ROW_t;
  typedef ROW_t [1:0] PANEL_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WALK    = 2'd1,
    S_RESTORE = 2'd2
  } state_t;

  localparam int N_LEDS = 8;

  function automatic logic has_red(PANEL_t p);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (p[r][c] == RED) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  function automatic PANEL_t fill(LED_t b0, LED_t b1);
    PANEL_t p;
    for (int c = 0; c < 4; c++) begin
      p[0][c] = b0;
      p[1][c] = b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/led_rr_arb.sv
// Two-requester round-robin arbiter for panel row writes.
// The pointer only advances when both requesters contend.
module led_rr_arb (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] REQ,
  input  logic       EN,
  output logic [1:0] GNT
);

  logic ptr;

  always_comb begin
    GNT = 2'b00;
    if (EN) begin
      if (REQ == 2'b11) GNT = ptr ? 2'b10 : 2'b01;
      else              GNT = REQ;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      ptr <= 1'b0;
    else if (EN && REQ == 2'b11)
      ptr <= ~ptr;
  end

endmodule

// File: rtl/led_panel_ctrl.sv
// LED panel sequencer: arbitrated row writes, walking-RED
// self-test, DANGER flag and saturating RED alert counter.
module led_panel_ctrl
  import led_pkg::*;
#(
  parameter int ROWS     = 2,
  parameter int COLS     = 4,
  parameter int STEP_CYC = 10,
  parameter int ALERT_W  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               TEST_START,
  input  logic [1:0]         BKGND_ROW0,
  input  logic [1:0]         BKGND_ROW1,
  input  logic [1:0]         REQ,
  input  logic [1:0]         REQ_ROW,
  input  logic [15:0]        REQ_DATA,
  output logic [1:0]         GNT,
  output logic [15:0]        PANEL,
  output logic               BUSY,
  output logic               TEST_DONE,
  output logic               DANGER,
  output logic [ALERT_W-1:0] ALERTS
);

  localparam int SW   = $clog2(ROWS * COLS);
  localparam int HW   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int LAST = N_LEDS - 1;

  state_t             state_q, state_d;
  PANEL_t             panel_q, panel_d, wr_p;
  logic [SW-1:0]      step_q, step_d;
  logic [HW-1:0]      hold_q, hold_d;
  LED_t               bg0_q, bg0_d, bg1_q, bg1_d;
  logic [ALERT_W-1:0] alerts_q, alerts_d;
  logic               danger_q;
  logic               arb_en;
  logic [1:0]         gnt;
  logic               sel;
  logic               row;
  logic [7:0]         wdata;

  function automatic PANEL_t walk(
    LED_t b0, LED_t b1, logic [SW-1:0] s
  );
    PANEL_t p;
    p = fill(b0, b1);
    p[int'(s) / COLS][int'(s) % COLS] = RED;
    return p;
  endfunction

  assign arb_en = (state_q == S_IDLE) && !TEST_START && !RST;

  led_rr_arb u_arb (
    .CLK (CLK),
    .RST (RST),
    .REQ (REQ),
    .EN  (arb_en),
    .GNT (gnt)
  );

  always_comb begin
    state_d  = state_q;
    panel_d  = panel_q;
    step_d   = step_q;
    hold_d   = hold_q;
    bg0_d    = bg0_q;
    bg1_d    = bg1_q;
    alerts_d = alerts_q;
    sel      = gnt[1];
    row      = REQ_ROW[sel];
    wdata    = sel ? REQ_DATA[15:8] : REQ_DATA[7:0];
    wr_p     = panel_q;
    wr_p[row] = ROW_t'(wdata);
    unique case (state_q)
      S_IDLE: begin
        if (TEST_START) begin
          state_d = S_WALK;
          step_d  = '0;
          hold_d  = '0;
          bg0_d   = LED_t'(BKGND_ROW0);
          bg1_d   = LED_t'(BKGND_ROW1);
          panel_d = walk(LED_t'(BKGND_ROW0),
                         LED_t'(BKGND_ROW1), '0);
        end else if (gnt != 2'b00) begin
          panel_d = wr_p;
          // Only genuine changes that carry RED are alerts.
          if (has_red(wr_p) && wr_p != panel_q &&
              alerts_q != '1)
            alerts_d = alerts_q + ALERT_W'(1);
        end
      end
      S_WALK: begin
        if (hold_q == HW'(STEP_CYC - 1)) begin
          hold_d = '0;
          if (step_q == SW'(LAST)) begin
            state_d = S_RESTORE;
            panel_d = fill(bg0_q, bg1_q);
          end else begin
            step_d  = step_q + SW'(1);
            panel_d = walk(bg0_q, bg1_q, step_q + SW'(1));
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_RESTORE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      panel_q  <= fill(BLU, BLU);
      step_q   <= '0;
      hold_q   <= '0;
      bg0_q    <= BLU;
      bg1_q    <= BLU;
      alerts_q <= '0;
      danger_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      panel_q  <= panel_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      bg0_q    <= bg0_d;
      bg1_q    <= bg1_d;
      alerts_q <= alerts_d;
      danger_q <= has_red(panel_q);
    end
  end

  assign GNT       = gnt;
  assign PANEL     = panel_q;
  assign BUSY      = (state_q != S_IDLE);
  assign TEST_DONE = (state_q == S_RESTORE);
  assign DANGER    = danger_q;
  assign ALERTS    = alerts_q;

endmodule

// File: tb/tb_led_panel_ctrl.sv
// Randomized scoreboard bench for led_panel_ctrl (8-bit and
// 2-bit alert counter instances driven in lockstep).
module tb_led_panel_ctrl;

  localparam int STEP = 10;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        TEST_START = 1'b0;
  logic [1:0]  BKGND_ROW0 = '0;
  logic [1:0]  BKGND_ROW1 = '0;
  logic [1:0]  REQ = '0;
  logic [1:0]  REQ_ROW = '0;
  logic [15:0] REQ_DATA = '0;

  logic [1:0]  gnt_a, gnt_b;
  logic [15:0] panel_a, panel_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic        danger_a, danger_b;
  logic [7:0]  alerts_a;
  logic [1:0]  alerts_b;

  led_panel_ctrl #(.ROWS(2), .COLS(4), .STEP_CYC(STEP),
                   .ALERT_W(8)) dut (
    .CLK(CLK), .RST(RST), .TEST_START(TEST_START),
    .BKGND_ROW0(BKGND_ROW0), .BKGND_ROW1(BKGND_ROW1),
    .REQ(REQ), .REQ_ROW(REQ_ROW), .REQ_DATA(REQ_DATA),
    .GNT(gnt_a), .PANEL(panel_a), .BUSY(busy_a),
    .TEST_DONE(done_a), .DANGER(danger_a), .ALERTS(alerts_a)
  );

  led_panel_ctrl #(.ROWS(2), .COLS(4), .STEP_CYC(STEP),
                   .ALERT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .TEST_START(TEST_START),
    .BKGND_ROW0(BKGND_ROW0), .BKGND_ROW1(BKGND_ROW1),
    .REQ(REQ), .REQ_ROW(REQ_ROW), .REQ_DATA(REQ_DATA),
    .GNT(gnt_b), .PANEL(panel_b), .BUSY(busy_b),
    .TEST_DONE(done_b), .DANGER(danger_b), .ALERTS(alerts_b)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] mp = '0;
  int          cnt = 0;
  bit          ptr = 1'b0;

  typedef struct {
    logic [1:0]  gnt;
    logic [15:0] panel;
    int          cnt;
  } gexp_t;

  typedef struct {
    logic [15:0] panel;
    bit          busy;
    bit          done;
    bit          danger;
    bit          chk_gnt;
    int          cnt;
  } wexp_t;

  gexp_t gq[$];
  wexp_t wq[$];

  function automatic bit red16(logic [15:0] p);
    for (int i = 0; i < 8; i++)
      if (p[2*i +: 2] == 2'd3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat(int c, int w);
    int m;
    m = (1 << w) - 1;
    return (c > m) ? m : c;
  endfunction

  task automatic model_write(int who, logic row,
                             logic [7:0] d);
    logic [15:0] np;
    gexp_t e;
    np = mp;
    np[8*int'(row) +: 8] = d;
    if (red16(np) && np != mp) cnt++;
    mp = np;
    e.gnt = (who == 0) ? 2'b01 : 2'b10;
    e.panel = mp;
    e.cnt = cnt;
    gq.push_back(e);
  endtask

  // ---------------- grant monitor ----------------
  gexp_t s1, s2;
  bit    s1v = 1'b0;
  bit    s2v = 1'b0;

  always @(negedge CLK) begin
    if (s2v) begin
      chk("danger", danger_a, red16(s2.panel));
      chk("danger2", danger_b, red16(s2.panel));
    end
    s2v = s1v;
    s2 = s1;
    if (s1v) begin
      chk("panel", panel_a, s1.panel);
      chk("panel2", panel_b, s1.panel);
      chk("alerts", alerts_a, sat(s1.cnt, 8));
      chk("alerts2", alerts_b, sat(s1.cnt, 2));
    end
    s1v = 1'b0;
    if (gnt_a != 2'b00 || gnt_b != 2'b00) begin
      if (gq.size() == 0) begin
        chk("unexpected_gnt", gnt_a, 2'b00);
      end else begin
        s1 = gq.pop_front();
        chk("gnt", gnt_a, s1.gnt);
        chk("gnt2", gnt_b, s1.gnt);
        s1v = 1'b1;
      end
    end
  end

  // ---------------- self-test monitor ----------------
  always @(negedge CLK) begin
    wexp_t w;
    if (wq.size() > 0) begin
      w = wq.pop_front();
      chk("walk_panel", panel_a, w.panel);
      chk("walk_panel2", panel_b, w.panel);
      chk("walk_busy", busy_a, w.busy);
      chk("walk_busy2", busy_b, w.busy);
      chk("walk_done", done_a, w.done);
      chk("walk_done2", done_b, w.done);
      chk("walk_danger", danger_a, w.danger);
      chk("walk_alerts", alerts_a, sat(w.cnt, 8));
      chk("walk_alerts2", alerts_b, sat(w.cnt, 2));
      if (w.chk_gnt) chk("walk_gnt", gnt_a, 2'b00);
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(logic [1:0] pat, logic [1:0] rows,
                       logic [7:0] d0, logic [7:0] d1);
    logic [1:0] pend, g;
    int first;
    @(posedge CLK);
    #1;
    REQ_ROW = rows;
    REQ_DATA = {d1, d0};
    REQ = pat;
    if (pat == 2'b11) begin
      first = ptr ? 1 : 0;
      model_write(first, rows[first],
                  first ? d1 : d0);
      model_write(1 - first, rows[1-first],
                  first ? d0 : d1);
      ptr = ~ptr;
    end else if (pat == 2'b10) begin
      model_write(1, rows[1], d1);
    end else begin
      model_write(0, rows[0], d0);
    end
    pend = pat;
    for (int t = 0; t < 8 && pend != 0; t++) begin
      @(negedge CLK);
      g = gnt_a;
      @(posedge CLK);
      #1;
      pend = pend & ~g;
      REQ = pend;
    end
    chk("req_served", pend, 2'b00);
    REQ = 2'b00;
  endtask

  task automatic rand_issue();
    logic [1:0] pat, rows;
    logic [7:0] d0, d1;
    pat = 2'($urandom_range(1, 3));
    rows = 2'($urandom);
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    if ($urandom_range(0, 3) == 0)
      d0 = mp[8*int'(rows[0]) +: 8];
    if ($urandom_range(0, 3) == 0)
      d1 = mp[8*int'(rows[1]) +: 8];
    issue(pat, rows, d0, d1);
    repeat ($urandom_range(0, 2)) @(posedge CLK);
  endtask

  task automatic run_test(logic [1:0] bg0, logic [1:0] bg1,
                          bit with_req);
    logic [15:0] fl, p, prev;
    logic [7:0]  d;
    logic        r;
    int          c0;
    bit          got;
    wexp_t       w;
    @(posedge CLK);
    #1;
    TEST_START = 1'b1;
    BKGND_ROW0 = bg0;
    BKGND_ROW1 = bg1;
    d = 8'($urandom);
    r = 1'($urandom);
    if (with_req) begin
      REQ_ROW = {1'b0, r};
      REQ_DATA = {8'h00, d};
      REQ = 2'b01;
    end
    c0 = cyc;
    fl = {{4{bg1}}, {4{bg0}}};
    prev = mp;
    for (int k = 0; k <= 8*STEP + 2; k++) begin
      if (k == 0) p = mp;
      else if (k <= 8*STEP) begin
        p = fl;
        p[2*((k-1)/STEP) +: 2] = 2'd3;
      end else p = fl;
      w.panel = p;
      w.busy = (k >= 1 && k <= 8*STEP + 1);
      w.done = (k == 8*STEP + 1);
      w.danger = red16(prev);
      w.chk_gnt = (k <= 8*STEP + 1);
      w.cnt = cnt;
      wq.push_back(w);
      prev = p;
    end
    mp = fl;
    if (with_req) model_write(0, r, d);
    @(posedge CLK);
    #1;
    TEST_START = 1'b0;
    BKGND_ROW0 = ~bg0;
    BKGND_ROW1 = ~bg1;
    repeat (20) @(posedge CLK);
    #1;
    TEST_START = 1'b1;
    @(posedge CLK);
    #1;
    TEST_START = 1'b0;
    if (with_req) begin
      got = 1'b0;
      for (int t = 0; t < 150 && !got; t++) begin
        @(negedge CLK);
        if (gnt_a != 2'b00) begin
          got = 1'b1;
          chk("gnt_after_test", cyc - c0, 8*STEP + 2);
        end
      end
      if (!got) chk("gnt_timeout", 0, 1);
      @(posedge CLK);
      #1;
      REQ = 2'b00;
    end
    for (int t = 0; t < 200 && wq.size() > 0; t++)
      @(negedge CLK);
    chk("walk_drained", wq.size(), 0);
  endtask

  task automatic reset_mid_test();
    bit seen;
    @(posedge CLK);
    #1;
    TEST_START = 1'b1;
    BKGND_ROW0 = 2'd1;
    BKGND_ROW1 = 2'd2;
    @(posedge CLK);
    #1;
    TEST_START = 1'b0;
    repeat (33) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_busy", busy_a, 1'b1);
    chk("mid_panel", panel_a, 16'hAA95 | 16'h00C0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    mp = '0;
    cnt = 0;
    ptr = 1'b0;
    @(negedge CLK);
    chk("rst_panel", panel_a, 16'h0000);
    chk("rst_panel2", panel_b, 16'h0000);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_alerts", alerts_a, 8'd0);
    chk("rst_alerts2", alerts_b, 2'd0);
    chk("rst_danger", danger_a, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge CLK);
      if (done_a || busy_a || done_b) seen = 1'b1;
    end
    chk("no_done_after_rst", seen, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RST = 1'b1;
    REQ = 2'b11;
    REQ_DATA = 16'h55AA;
    REQ_ROW = 2'b10;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_gnt", gnt_a, 2'b00);
    chk("rst_panel0", panel_a, 16'h0000);
    chk("rst_busy0", busy_a, 1'b0);
    chk("rst_done0", done_a, 1'b0);
    chk("rst_danger0", danger_a, 1'b0);
    chk("rst_alerts0", alerts_a, 8'd0);
    @(posedge CLK);
    #1;
    REQ = 2'b00;
    RST = 1'b0;

    issue(2'b11, 2'b10, 8'hAA, 8'h55);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("plan_panel_55aa", panel_a, 16'h55AA);
    chk("plan_danger_0", danger_a, 1'b0);
    issue(2'b01, 2'b00, 8'h03, 8'h00);
    issue(2'b01, 2'b00, 8'h03, 8'h00);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("plan_alerts_1", alerts_a, 8'd1);
    chk("plan_danger_1", danger_a, 1'b1);

    run_test(2'd1, 2'd2, 1'b1);
    for (int i = 0; i < 400; i++) rand_issue();
    run_test(2'($urandom), 2'($urandom), 1'b0);
    reset_mid_test();
    for (int i = 0; i < 20; i++) rand_issue();
    repeat (5) @(posedge CLK);
    chk("gq_empty", gq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
